// File: rtl/spwm_gate_ctrl_pkg.sv
// Shared types and constants for the SPWM gate controller: gate FSM states,
// modulation-index scale and the internal datapath widths.
package spwm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEAD_TO_HI,
        ST_HI,
        ST_DEAD_TO_LO,
        ST_LO
    } gate_state_t;

    // Modulation index is carried in tenths, so 10 means unity gain.
    localparam int MA_SCALE   = 10;
    localparam int DEAD_CNT_W = 10;

    function automatic int prod_width(input int w);
        return w + 8;
    endfunction

    function automatic logic is_dead(input gate_state_t s);
        return (s == ST_DEAD_TO_HI) || (s == ST_DEAD_TO_LO);
    endfunction

endpackage

// File: rtl/spwm_gate_ctrl_if.sv
// Modulation-index configuration channel: the master offers an index in
// tenths with cfg_valid, the controller accepts it when cfg_ready is high.
interface spwm_gate_ctrl_if;

    logic       cfg_valid;
    logic [7:0] cfg_ma;
    logic       cfg_ready;

    modport master (output cfg_valid, output cfg_ma, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_ma, output cfg_ready);

endinterface

// File: rtl/spwm_ref_scaler.sv
// Combinational reference scaling: ref_in * ma / 10, saturated to the
// carrier range. The parent registers the result at a carrier valley.
module spwm_ref_scaler
    import spwm_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] ref_in,
    input  logic [7:0]   ma,
    output logic [W-1:0] scaled
);

    localparam int PW = prod_width(W);

    logic [PW-1:0] product;
    logic [PW-1:0] quotient;

    assign product  = PW'(ref_in) * PW'(ma);
    assign quotient = product / PW'(MA_SCALE);

    // Any bit above the carrier width means the scaled value overshoots full scale.
    assign scaled = (|quotient[PW-1:W]) ? {W{1'b1}} : quotient[W-1:0];

endmodule

// File: rtl/spwm_gate_ctrl.sv
// One inverter leg: compares the scaled reference against the triangular
// carrier and drives complementary gates with dead time. Build option
// SPWM_FAULT_EN adds a latched fault input that forces both gates off.
module spwm_gate_ctrl
    import spwm_pkg::*;
#(
    parameter int W           = 16,
    parameter int DEAD_CYCLES = 50,
    parameter int MA_DEFAULT  = 10,
    parameter int MA_MAX      = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [W-1:0]     carrier,
    input  logic             carrier_dir,
    input  logic [W-1:0]     ref_in,
`ifdef SPWM_FAULT_EN
    input  logic             fault,
    output logic             fault_latched,
`endif
    spwm_gate_ctrl_if.slave  cfg,
    output logic [7:0]       ma_active,
    output logic             sample_strobe,
    output logic             gate_hi,
    output logic             gate_lo
);

    logic                  dir_q;
    logic                  valley;
    logic                  demand_q;
    logic                  pending_valid;
    logic [7:0]            pending_ma;
    logic [7:0]            ma_next;
    logic [7:0]            cfg_ma_clamped;
    logic [W-1:0]          ref_q;
    logic [W-1:0]          scaled;
    logic                  kill;
    gate_state_t           state;
    gate_state_t           state_next;
    logic [DEAD_CNT_W-1:0] dead_cnt;

    assign valley         = dir_q & ~carrier_dir;
    assign ma_next        = pending_valid ? pending_ma : ma_active;
    assign cfg_ma_clamped = (cfg.cfg_ma > 8'(MA_MAX)) ? 8'(MA_MAX) : cfg.cfg_ma;
    assign cfg.cfg_ready  = ~pending_valid;

`ifdef SPWM_FAULT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_latched <= 1'b0;
        end else if (fault) begin
            fault_latched <= 1'b1;
        end
    end

    assign kill = ~enable | fault | fault_latched;
`else
    assign kill = ~enable;
`endif

    spwm_ref_scaler #(.W(W)) u_scaler (
        .ref_in (ref_in),
        .ma     (ma_next),
        .scaled (scaled)
    );

    // A transfer can only happen while nothing is pending, so it never collides
    // with the valley consuming the pending index; an index accepted on a valley
    // waits for the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q         <= 1'b0;
            sample_strobe <= 1'b0;
            demand_q      <= 1'b0;
            ref_q         <= '0;
            ma_active     <= 8'(MA_DEFAULT);
            pending_valid <= 1'b0;
            pending_ma    <= '0;
        end else begin
            dir_q         <= carrier_dir;
            sample_strobe <= valley;
            demand_q      <= (ref_q > carrier);
            if (valley) begin
                ma_active <= ma_next;
                ref_q     <= scaled;
            end
            if (valley && pending_valid) begin
                pending_valid <= 1'b0;
            end else if (cfg.cfg_valid && !pending_valid) begin
                pending_valid <= 1'b1;
                pending_ma    <= cfg_ma_clamped;
            end
        end
    end

    always_comb begin
        state_next = state;
        if (kill) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:       state_next = ST_DEAD_TO_LO;
                ST_LO:         if (demand_q)  state_next = ST_DEAD_TO_HI;
                ST_HI:         if (!demand_q) state_next = ST_DEAD_TO_LO;
                ST_DEAD_TO_HI,
                ST_DEAD_TO_LO: if (dead_cnt == DEAD_CNT_W'(1))
                                   state_next = demand_q ? ST_HI : ST_LO;
                default:       state_next = ST_IDLE;
            endcase
        end
    end

    // Gates are decoded from the next state so they change on the same edge as the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            dead_cnt <= '0;
            gate_hi  <= 1'b0;
            gate_lo  <= 1'b0;
        end else begin
            state   <= state_next;
            gate_hi <= (state_next == ST_HI);
            gate_lo <= (state_next == ST_LO);
            if (is_dead(state_next) && !is_dead(state)) begin
                dead_cnt <= DEAD_CNT_W'(DEAD_CYCLES);
            end else if (is_dead(state)) begin
                dead_cnt <= dead_cnt - DEAD_CNT_W'(1);
            end
        end
    end

endmodule
